// File: rtl/p2s_lanes_stream.sv
// p2s_lanes_stream: streams valid/ready words out over LANES serial lines, one holding word behind the shifter.
// Build option P2S_PARITY_EN appends one even-parity beat per lane after the data beats.
module p2s_lanes_stream #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned LANES     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 msb_first_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [LANES-1:0]     serial_o,
    output logic                 frame_o,
    output logic                 first_o,
    output logic                 last_o,
    output logic                 busy_o
);

    localparam int unsigned SLICE = DATA_SIZE / LANES;
`ifdef P2S_PARITY_EN
    localparam int unsigned BEATS = SLICE + 1;
`else
    localparam int unsigned BEATS = SLICE;
`endif
    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    // Per-lane bit for a given beat: each lane walks its own slice, then optionally its parity.
    function automatic logic [LANES-1:0] lane_bits(
        input logic [DATA_SIZE-1:0] d,
        input logic                 msb,
        input logic [CW-1:0]        b
    );
        logic [LANES-1:0] r;
        logic [SLICE-1:0] sl;
        r = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sl = d[l*SLICE +: SLICE];
            for (int unsigned i = 0; i < SLICE; i++) begin
                if (b == CW'(msb ? (SLICE - 1 - i) : i)) r[l] = sl[i];
            end
`ifdef P2S_PARITY_EN
            if (b == LAST_BEAT) r[l] = ^sl;
`endif
        end
        return r;
    endfunction

    logic                 h_v, h_v_d;
    logic [DATA_SIZE-1:0] h_data, h_data_d;
    logic                 h_msb, h_msb_d;
    logic                 s_v, s_v_d;
    logic [DATA_SIZE-1:0] s_data, s_data_d;
    logic                 s_msb, s_msb_d;
    logic [CW-1:0]        beat, beat_d;
    logic [LANES-1:0]     serial_q, serial_d;

    logic s_last;
    logic pull;
    logic accept;

    assign s_last  = s_v & (beat == LAST_BEAT);
    assign pull    = h_v & (~s_v | s_last);
    assign ready_o = ~h_v | pull;
    assign accept  = valid_i & ready_o;

    always_comb begin
        h_v_d    = h_v;
        h_data_d = h_data;
        h_msb_d  = h_msb;
        if (accept) begin
            h_v_d    = 1'b1;
            h_data_d = data_i;
            h_msb_d  = msb_first_i;
        end else if (pull) begin
            h_v_d    = 1'b0;
        end
    end

    always_comb begin
        s_v_d    = s_v;
        s_data_d = s_data;
        s_msb_d  = s_msb;
        beat_d   = beat;
        if (pull) begin
            s_v_d    = 1'b1;
            s_data_d = h_data;
            s_msb_d  = h_msb;
            beat_d   = '0;
        end else if (s_last) begin
            s_v_d    = 1'b0;
            beat_d   = '0;
        end else if (s_v) begin
            beat_d   = beat + CW'(1);
        end
    end

    // serial_o is a true register: compute the bit for the beat that the next S state will show.
    always_comb begin
        serial_d = '0;
        if (s_v_d) serial_d = lane_bits(s_data_d, s_msb_d, beat_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_v      <= 1'b0;
            h_data   <= '0;
            h_msb    <= 1'b0;
            s_v      <= 1'b0;
            s_data   <= '0;
            s_msb    <= 1'b0;
            beat     <= '0;
            serial_q <= '0;
        end else begin
            h_v      <= h_v_d;
            h_data   <= h_data_d;
            h_msb    <= h_msb_d;
            s_v      <= s_v_d;
            s_data   <= s_data_d;
            s_msb    <= s_msb_d;
            beat     <= beat_d;
            serial_q <= serial_d;
        end
    end

    assign serial_o = serial_q;
    assign frame_o  = s_v;
    assign first_o  = s_v & (beat == '0);
    assign last_o   = s_last;
    assign busy_o   = h_v | s_v;

endmodule

// File: doc/p2s_lanes_stream.md
# p2s_lanes_stream

Streaming parallel-to-serial converter, the parametrised successor of the single-shot converter. It accepts words over a valid/ready handshake and buffers one word behind the word being shifted, so consecutive words serialise with no idle cycles. It splits each word across `LANES` serial outputs, and the bit order is selectable per word. It sits between a word-wide producer and serial links or pins that run at clock rate, one bit per cycle per lane.

## Interface
- `DATA_SIZE`, 8: word width in bits; must be a multiple of `LANES`.
- `LANES`, 1: number of parallel serial outputs; 1..`DATA_SIZE`.
- Derived values:
  - `BEATS` = `DATA_SIZE/LANES`, plus 1 when parity is compiled in.
  - Counter width = max(1, $clog2(`BEATS`)).

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data_i`  in  `DATA_SIZE`  word to serialise.
- `msb_first_i`  in  1  bit order, sampled together with `data_i` on accept: 1 = MSB first, 0 = LSB first.
- `valid_i`  in  1  producer has a word.
- `ready_o`  out  1  block can take a word this cycle.
- `serial_o`  out  `LANES`  one bit per lane, registered.
- `frame_o`  out  1  `serial_o` carries a valid beat.
- `first_o`  out  1  beat 0 of a word; qualified by `frame_o`.
- `last_o`  out  1  final beat of a word; qualified by `frame_o`.
- `busy_o`  out  1  a word is held or being shifted.

## Operation
- **Accept:** a word transfers on any rising edge where `valid_i & ready_o`.
- **Holding register H:** flag `h_v`; stores the accepted word and its `msb_first_i`.
- **Shift register S:** flag `s_v` plus a beat counter `beat`, running 0..`BEATS`-1.
- **Pull:** `pull = h_v & (~s_v | (beat == BEATS-1))`. On a pull edge, S loads from H and `beat` resets to 0.
- **ready_o:** `~h_v | pull`. There is no combinational path from `valid_i` to `ready_o`.
- **H flag update:**
  - An accept on the same edge as a pull refills H, so `h_v` stays 1.
  - A pull with no accept clears `h_v`.
- **S flag update:** if S is on its last beat and there is no pull, S clears `s_v`.
- **Lane mapping:** lane `l` carries slice `data[l*(DATA_SIZE/LANES) +: DATA_SIZE/LANES]`.
  - MSB-first: the slice is sent from its top bit downward.
  - LSB-first: the slice is sent from bit 0 upward.
- **Outputs:**
  - `serial_o`, `frame_o`, `first_o` and `last_o` are driven from S state.
  - `frame_o` = `s_v`; `first_o` = `s_v & (beat == 0)`; `last_o` = `s_v & (beat == BEATS-1)`.
  - `busy_o` = `h_v | s_v`.
- **Idle:** while `s_v` = 0, `serial_o` is all zeros.
- **Single-beat case:** with `LANES` = `DATA_SIZE` and no parity, `BEATS` = 1. Each word occupies one cycle, and `first_o`/`last_o` are both high on that cycle.

## Timing
- **Reset:** on an edge with `rst_n` = 0:
  - `h_v`, `s_v` and `beat` are cleared, and `serial_o` = 0.
  - `frame_o`, `first_o`, `last_o` and `busy_o` are 0.
  - `ready_o` is 1 from the first cycle after reset.
- **Reset mid-word:** aborts both the current word and the held word with no further beats. Partial words are not resumed.
- **Latency:** a word accepted at edge k into an empty block is in H after k. It loads S at edge k+1, so its first beat is on `serial_o` during the cycle after edge k+1.
- **Throughput:** with `valid_i` held high, words stream gap-free and `frame_o` stays continuously high.
  - `ready_o` is high for one cycle per word, on the last beat of the word in S.
  - With `BEATS` = 1, `ready_o` is high every cycle.
- **Back-pressure:** with both H and S full, `ready_o` = 0. The producer must hold `data_i`/`msb_first_i` stable until accepted.
- **Input changes:** `msb_first_i` changes after acceptance do not affect the word in flight.

## Configuration
- `P2S_PARITY_EN` defined:
  - `BEATS` gains one extra final beat.
  - On it, each lane outputs the XOR of its data slice (even parity over slice plus parity bit).
  - `last_o` marks the parity beat.
- `P2S_PARITY_EN` undefined: no parity beat and no parity logic.

## Test plan
- **MSB-first, 1 lane:** `LANES`=1, `msb_first_i`=1, accept 0xC1 into an idle block.
  - Two cycles later `serial_o` = 1,1,0,0,0,0,0,1 over 8 cycles, with `frame_o` high for all 8.
  - `first_o` is high on beat 0 and `last_o` on beat 7.
- **LSB-first:** same as above with `msb_first_i`=0; `serial_o` = 1,0,0,0,0,0,1,1.
- **4 lanes:** `LANES`=4, MSB-first, accept 0xB4; beat 0 `serial_o` = 4'b1100, beat 1 = 4'b0110; `first_o`/`last_o` on beats 0/1.
- **Back-to-back:** `LANES`=1, `valid_i` high with 0x01, 0x80, 0xFF queued.
  - `frame_o` high for 24 consecutive cycles.
  - `ready_o` high only on cycles where `last_o` is high (after the initial fill).
  - Output stream matches all three words in order.
- **Reset mid-word:** deassert `rst_n` on beat 3 of 0xAA with a second word held.
  - The next cycle shows `frame_o`=0, `busy_o`=0, `serial_o`=0 and `ready_o`=1.
  - Neither word resumes.
- **Parity:** with `P2S_PARITY_EN`, `LANES`=1, accept 0xC1; 9 beats occur, beat 8 = 1, and `last_o` is high on beat 8 only.
